sn89_wr_queue: RTL

Buffered write transmitter for the two SN76489 (jt89) sound chips. It sits between the audio CPU I/O decode and the jt89 `din`/`wr_n`/`ready` pins. It accepts byte writes tagged with a target chip into a FIFO and drains them one at a time. Each drained byte is bit-reversed onto the chip data bus, and a `wr_n` strobe timed to the chip clock enable is issued only when the target chip reports ready.

---
 rtl/sn89_wr_queue_if.sv | 30 +++
 rtl/sn89_wr_queue.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sn89_wr_queue_if.sv
// rtl/sn89_wr_queue_if.sv - CPU push side and jt89 chip side of sn89_wr_queue
interface sn89_wr_queue_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  clk_en;
  logic                  cpu_wr;
  logic                  cpu_sel;
  logic [7:0]            cpu_data;
  logic                  clr_ovf;
  logic                  sn1_rdy;
  logic                  sn2_rdy;
  logic [7:0]            sn_din;
  logic                  sn1_wr_n;
  logic                  sn2_wr_n;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  busy;

  modport master (
    output clk_en, cpu_wr, cpu_sel, cpu_data, clr_ovf, sn1_rdy, sn2_rdy,
    input  sn_din, sn1_wr_n, sn2_wr_n, count, empty, full, overflow, busy
  );

  modport slave (
    input  clk_en, cpu_wr, cpu_sel, cpu_data, clr_ovf, sn1_rdy, sn2_rdy,
    output sn_din, sn1_wr_n, sn2_wr_n, count, empty, full, overflow, busy
  );
endinterface

// File: rtl/sn89_wr_queue.sv
// rtl/sn89_wr_queue.sv - buffered SN76489 write queue with bit-reversed, clk_en-timed wr_n strobes
// A {sel,data} FIFO drained by a four-state FSM that paces each chip write on clk_en and ready.
module sn89_wr_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int STROBE_LEN = 2
) (
  input  logic           clk_sys,
  input  logic           reset,
  sn89_wr_queue_if.slave bus
);
  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [3:0]            LAST_TICK = 4'(STROBE_LEN);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT_RDY} state_t;

  state_t                state, state_nx;
  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nx;
  logic                  empty, full, overflow;
  logic                  push, pop;
  logic [8:0]            head;
  logic                  sel, sel_nx;
  logic [7:0]            din, din_nx;
  logic [3:0]            tick, tick_nx;
  logic                  busy, wr1_n, wr2_n;
  logic                  rdy;

  // full is sampled as registered, so a same-cycle pop never makes room for a push
  assign push = bus.cpu_wr && !full;
  assign pop  = (state == IDLE) && !empty;
  assign head = mem[rd_ptr];
  assign rdy  = sel ? bus.sn2_rdy : bus.sn1_rdy;

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CNT_ONE;
    else if (pop && !push)
      count_nx = count - CNT_ONE;
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      mem[wr_ptr] <= {bus.cpu_sel, bus.cpu_data};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nx;
      empty <= (count_nx == '0);
      full  <= (count_nx == FULL_CNT);
      if (bus.cpu_wr && full)
        overflow <= 1'b1;
      else if (bus.clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    din_nx   = din;
    tick_nx  = tick;
    case (state)
      IDLE: begin
        if (!empty) begin
          sel_nx = head[8];
          for (int i = 0; i < 8; i++)
            din_nx[i] = head[7-i];
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (bus.clk_en && rdy) begin
          state_nx = STROBE;
          tick_nx  = '0;
        end
      end
      STROBE: begin
        if (bus.clk_en) begin
          if (tick + 4'd1 == LAST_TICK) begin
            state_nx = WAIT_RDY;
            tick_nx  = '0;
          end else begin
            tick_nx = tick + 4'd1;
          end
        end
      end
      WAIT_RDY: begin
        // the first tick after the strobe gives the chip time to drop ready
        if (bus.clk_en) begin
          if (tick == '0)
            tick_nx = 4'd1;
          else if (rdy)
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 1'b0;
      din   <= '0;
      tick  <= '0;
      busy  <= 1'b0;
      wr1_n <= 1'b1;
      wr2_n <= 1'b1;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      din   <= din_nx;
      tick  <= tick_nx;
      busy  <= (state_nx != IDLE);
      wr1_n <= !((state_nx == STROBE) && !sel_nx);
      wr2_n <= !((state_nx == STROBE) && sel_nx);
    end
  end

  assign bus.sn_din   = din;
  assign bus.sn1_wr_n = wr1_n;
  assign bus.sn2_wr_n = wr2_n;
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.busy     = busy;
endmodule
